hssi_reset_sequencer: RTL and testbench

//  Release-side counterpart of the per-stage reset-delay filters. Holds a chain of HSSI stages
//  (e.g. PLL -> TX -> RX) in reset, then releases them one stage at a time. Each stage's ready

---
 rtl/hssi_rstseq_pkg.sv | 22 ++
 rtl/hssi_rstseq_timer.sv | 40 ++++
 rtl/hssi_reset_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hssi_reset_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssi_rstseq_pkg.sv
// ============================================================================
// Module      : hssi_rstseq_pkg
// Description : Shared types and widths for the HSSI reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hssi_rstseq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_UP   = 2'd2,
        ST_FAIL = 2'd3
    } rstseq_state_t;

    localparam int c_stage_w    = 3;
    localparam int c_loss_cnt_w = 8;

endpackage

`default_nettype wire

// File: rtl/hssi_rstseq_timer.sv
// ============================================================================
// Module      : hssi_rstseq_timer
// Description : Per-stage wait timer; saturating up-counter with sync clear
//               and a registered terminal (all-ones) flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hssi_rstseq_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] c_ones = '1;

    logic [WIDTH-1:0] r_cnt;
    logic             r_term;

    // The flag rises together with the count reaching all-ones; counting stops there.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt  <= '0;
            r_term <= 1'b0;
        end else if (!r_term) begin
            r_cnt  <= r_cnt + WIDTH'(1);
            r_term <= (r_cnt + WIDTH'(1)) == c_ones;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = r_term;

endmodule

`default_nettype wire

// File: rtl/hssi_reset_sequencer.sv
// ============================================================================
// Module      : hssi_reset_sequencer
// Description : Releases a chain of HSSI stage resets one stage at a time with
//               timeout/retry. Optional loss counter: HSSI_RSTSEQ_LOSS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hssi_reset_sequencer
    import hssi_rstseq_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int TIMEOUT_BITS = 20,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_reset,
    input  logic [NUM_STAGES-1:0]   stage_ready,
    output logic [NUM_STAGES-1:0]   stage_rst_n,
    output logic                    all_ready,
    output logic                    fail,
    output logic [c_stage_w-1:0]    cur_stage
`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
    ,
    output logic [c_loss_cnt_w-1:0] loss_cnt
`endif
);

    localparam int                   c_hold_w     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [3:0]           c_retry_max  = 4'(MAX_RETRIES);
    localparam logic [c_stage_w-1:0] c_stage_last = c_stage_w'(NUM_STAGES - 1);

    rstseq_state_t           r_state, w_state;
    logic [c_hold_w-1:0]     r_hold_cnt, w_hold_cnt;
    logic [3:0]              r_retry, w_retry;
    logic [c_stage_w-1:0]    r_stage, w_stage;
    logic [NUM_STAGES-1:0]   r_stage_rst_n, w_stage_rst_n;
    logic                    r_all_ready, w_all_ready;
    logic                    r_fail, w_fail;

    logic [TIMEOUT_BITS-1:0] w_timer_cnt;
    logic                    w_timer_term;
    logic                    w_timer_clr;
    logic                    w_cur_ready;
    logic                    w_loss;
    logic                    w_qual;
    logic                    w_event;

    hssi_rstseq_timer #(
        .WIDTH (TIMEOUT_BITS)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_timer_clr),
        .o_cnt  (w_timer_cnt),
        .o_term (w_timer_term)
    );

    // Ready of the stage being waited on, and loss of any already-released stage.
    always_comb begin
        w_cur_ready = 1'b0;
        w_loss      = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (j == int'(r_stage))
                w_cur_ready = stage_ready[j];
            if ((j < int'(r_stage)) && !stage_ready[j])
                w_loss = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_retry       <= '0;
            r_stage       <= '0;
            r_stage_rst_n <= '0;
            r_all_ready   <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hold_cnt    <= w_hold_cnt;
            r_retry       <= w_retry;
            r_stage       <= w_stage;
            r_stage_rst_n <= w_stage_rst_n;
            r_all_ready   <= w_all_ready;
            r_fail        <= w_fail;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_hold_cnt    = r_hold_cnt;
        w_retry       = r_retry;
        w_stage       = r_stage;
        w_stage_rst_n = r_stage_rst_n;
        w_all_ready   = r_all_ready;
        w_fail        = r_fail;
        w_timer_clr   = 1'b1;
        w_event       = 1'b0;
        // Ready seen on the release cycle itself may be stale, so it needs timer >= 1.
        w_qual        = (w_timer_cnt != '0) && w_cur_ready;

        if (req_reset) begin
            w_state       = ST_HOLD;
            w_hold_cnt    = '0;
            w_retry       = '0;
            w_fail        = 1'b0;
            w_stage       = '0;
            w_stage_rst_n = '0;
            w_all_ready   = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        w_state       = ST_WAIT;
                        w_stage       = '0;
                        w_stage_rst_n = NUM_STAGES'(1);
                    end else begin
                        w_hold_cnt = r_hold_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    w_timer_clr = 1'b0;
                    if (w_loss || (w_timer_term && !w_qual)) begin
                        w_event       = 1'b1;
                        w_timer_clr   = 1'b1;
                        w_stage       = '0;
                        w_stage_rst_n = '0;
                        w_hold_cnt    = '0;
                        if (r_retry == c_retry_max) begin
                            w_state = ST_FAIL;
                            w_fail  = 1'b1;
                        end else begin
                            w_state = ST_HOLD;
                            w_retry = r_retry + 1'b1;
                        end
                    end else if (w_qual) begin
                        w_timer_clr = 1'b1;
                        if (r_stage == c_stage_last) begin
                            w_state     = ST_UP;
                            w_all_ready = 1'b1;
                            w_retry     = '0;
                            w_stage     = '0;
                        end else begin
                            w_stage       = r_stage + 1'b1;
                            w_stage_rst_n = NUM_STAGES'({r_stage_rst_n, 1'b1});
                        end
                    end
                end
                ST_UP: begin
                    // Losing ready after a full bring-up re-sequences without spending a retry.
                    if (stage_ready != '1) begin
                        w_event       = 1'b1;
                        w_state       = ST_HOLD;
                        w_hold_cnt    = '0;
                        w_stage_rst_n = '0;
                        w_all_ready   = 1'b0;
                    end
                end
                ST_FAIL: begin
                    w_state = ST_FAIL;
                end
                default: begin
                    w_state = ST_HOLD;
                end
            endcase
        end
    end

`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
    logic [c_loss_cnt_w-1:0] r_loss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_loss_cnt <= '0;
        else if (w_event && (r_loss_cnt != '1))
            r_loss_cnt <= r_loss_cnt + 1'b1;
    end

    assign loss_cnt = r_loss_cnt;
`endif

    assign stage_rst_n = r_stage_rst_n;
    assign all_ready   = r_all_ready;
    assign fail        = r_fail;
    assign cur_stage   = r_stage;

endmodule

`default_nettype wire

// File: tb/tb_hssi_reset_sequencer.sv
// ============================================================================
// Module      : tb_hssi_reset_sequencer
// Description : Self-checking bench for hssi_reset_sequencer against a
//               cycle-level behavioural model with randomized stage behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hssi_reset_sequencer;

    localparam int N    = 3;
    localparam int H    = 16;
    localparam int TB   = 8;
    localparam int MR   = 2;
    localparam int TMAX = (1 << TB) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_reset;
    logic [N-1:0] stage_ready;
    logic [N-1:0] stage_rst_n;
    logic         all_ready;
    logic         fail;
    logic [2:0]   cur_stage;
`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
    logic [7:0]   loss_cnt;
`endif

    always #5 clk = ~clk;

    hssi_reset_sequencer #(
        .NUM_STAGES   (N),
        .HOLD_CYCLES  (H),
        .TIMEOUT_BITS (TB),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_reset   (req_reset),
        .stage_ready (stage_ready),
        .stage_rst_n (stage_rst_n),
        .all_ready   (all_ready),
        .fail        (fail),
        .cur_stage   (cur_stage)
`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
        ,
        .loss_cnt    (loss_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: mode 0=holding, 1=waiting on stage m_k, 2=up, 3=failed; m_rel = stages released.
    int m_mode, m_hold, m_k, m_wt, m_retry, m_rel, m_loss;
    bit m_all, m_fail;

    // Environment: stage j reports ready dly[j] cycles after its reset is released.
    int           dly[N];
    int           age[N];
    logic [N-1:0] f_hi, f_lo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] v = '0;
        for (int j = 0; j < m_rel; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic void model_step(input bit rn, input bit rq, input logic [N-1:0] rdy);
        bit lost, qual;
        if (!rn) begin
            m_mode = 0; m_hold = 0; m_k = 0; m_wt = 0; m_retry = 0;
            m_rel = 0; m_all = 0; m_fail = 0; m_loss = 0;
        end else if (rq) begin
            m_mode = 0; m_hold = 0; m_k = 0; m_rel = 0; m_all = 0; m_retry = 0; m_fail = 0;
        end else if (m_mode == 0) begin
            if (m_hold == H - 1) begin
                m_mode = 1; m_rel = 1; m_k = 0; m_wt = 0;
            end else m_hold++;
        end else if (m_mode == 1) begin
            lost = 0;
            for (int j = 0; j < m_k; j++) if (!rdy[j]) lost = 1;
            qual = (m_wt >= 1) && rdy[m_k];
            if (lost || (m_wt == TMAX && !qual)) begin
                if (m_loss < 255) m_loss++;
                m_rel = 0; m_k = 0; m_hold = 0;
                if (m_retry == MR) begin m_mode = 3; m_fail = 1; end
                else begin m_retry++; m_mode = 0; end
            end else if (qual) begin
                if (m_k == N - 1) begin m_mode = 2; m_all = 1; m_retry = 0; m_k = 0; end
                else begin m_k++; m_rel++; m_wt = 0; end
            end else m_wt++;
        end else if (m_mode == 2) begin
            if (rdy != {N{1'b1}}) begin
                if (m_loss < 255) m_loss++;
                m_mode = 0; m_hold = 0; m_rel = 0; m_all = 0;
            end
        end
    endfunction

    task automatic compare_all();
        chk("stage_rst_n", 32'(stage_rst_n), 32'(exp_rst()));
        chk("all_ready", 32'(all_ready), 32'(m_all));
        chk("fail", 32'(fail), 32'(m_fail));
        chk("cur_stage", 32'(cur_stage), (m_mode == 1) ? m_k : 0);
`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
        chk("loss_cnt", 32'(loss_cnt), m_loss);
`endif
    endtask

    task automatic tick();
        logic [N-1:0] r;
        for (int j = 0; j < N; j++)
            stage_ready[j] = !f_lo[j] && (f_hi[j] || (age[j] >= 0 && age[j] >= dly[j]));
        @(posedge clk);
        model_step(rst_n, req_reset, stage_ready);
        r = exp_rst();
        for (int j = 0; j < N; j++) age[j] = r[j] ? age[j] + 1 : -1;
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_reset = 1'b0; f_hi = '0; f_lo = '0;
        for (int j = 0; j < N; j++) begin dly[j] = 10; age[j] = -1; end
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic watch(input int n, output int t0, output int t1, output int t2,
                         output int ta, output int tf);
        t0 = -1; t1 = -1; t2 = -1; ta = -1; tf = -1;
        repeat (n) begin
            tick();
            if (t0 < 0 && stage_rst_n == 3'b001) t0 = cyc;
            if (t1 < 0 && stage_rst_n == 3'b011) t1 = cyc;
            if (t2 < 0 && stage_rst_n == 3'b111) t2 = cyc;
            if (ta < 0 && all_ready) ta = cyc;
            if (tf < 0 && fail) tf = cyc;
        end
    endtask

    initial begin
        int t0, t1, t2, ta, tf, c;
        logic [N-1:0] base_lo;
        rst_n = 1'b0; req_reset = 1'b0; f_hi = '0; f_lo = '0; stage_ready = '0;
        for (int j = 0; j < N; j++) begin dly[j] = 10; age[j] = -1; end

        // Reset values and normal bring-up
        do_reset();
        chk("reset_rst_n", 32'(stage_rst_n), 0);
        chk("reset_all_ready", 32'(all_ready), 0);
        chk("reset_cur_stage", 32'(cur_stage), 0);
        watch(55, t0, t1, t2, ta, tf);
        chk("bringup_s0", t0, 16);
        chk("bringup_s1", t1, 27);
        chk("bringup_s2", t2, 38);
        chk("bringup_all", ta, 49);
        chk("bringup_fail", tf, -1);

        // Stale ready
        do_reset();
        f_hi = '1;
        watch(30, t0, t1, t2, ta, tf);
        chk("stale_s1", t1, 18);
        chk("stale_all", ta, 22);

        // Timeout and retry, then recovery from FAIL
        do_reset();
        f_lo = 3'b010;
        watch(860, t0, t1, t2, ta, tf);
        chk("timeout_fail_cycle", tf, 849);
        repeat (20) tick();
        chk("fail_sticky", 32'(fail), 1);
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        c = cyc;
        chk("fail_cleared", 32'(fail), 0);
        watch(20, t0, t1, t2, ta, tf);
        chk("restart_s0", t0 - c, 16);

        // Loss in UP
        do_reset();
        watch(55, t0, t1, t2, ta, tf);
        f_lo = 3'b001;
        tick();
        f_lo = '0;
        chk("uploss_all_ready", 32'(all_ready), 0);
        chk("uploss_rst_n", 32'(stage_rst_n), 0);
        watch(40, t0, t1, t2, ta, tf);
        chk("uploss_reseq_s0", t0, 72);

        // req_reset coinciding with the last stage's ready
        do_reset();
        repeat (48) tick();
        chk("simul_cur_stage", 32'(cur_stage), 2);
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        chk("simul_all_ready", 32'(all_ready), 0);
        chk("simul_rst_n", 32'(stage_rst_n), 0);

        // rst_n mid-WAIT
        do_reset();
        repeat (30) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midwait_rst_n", 32'(stage_rst_n), 0);
        chk("midwait_cur_stage", 32'(cur_stage), 0);

        // Randomized delays, stuck stages, glitches, resets
        do_reset();
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < N; j++) dly[j] = $urandom_range(0, 15);
            base_lo = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            repeat (600) begin
                req_reset = ($urandom_range(0, 199) == 0);
                rst_n     = ($urandom_range(0, 499) != 0);
                f_lo      = base_lo;
                if ($urandom_range(0, 29) == 0) f_lo = f_lo | N'(1 << $urandom_range(0, N - 1));
                tick();
            end
        end
        req_reset = 1'b0; rst_n = 1'b1; f_lo = '0;

`ifdef HSSI_RSTSEQ_LOSS_CNT_EN
        // Loss counter saturation
        do_reset();
        f_hi = '1;
        c = 0;
        for (int g = 0; g < 12000 && c < 300; g++) begin
            if (all_ready) begin
                f_lo = '1;
                tick();
                f_lo = '0;
                c++;
            end else tick();
        end
        chk("losses_forced", c, 300);
        chk("loss_cnt_sat", 32'(loss_cnt), 255);
        req_reset = 1'b1;
        tick();
        req_reset = 1'b0;
        chk("loss_cnt_req", 32'(loss_cnt), 255);
        do_reset();
        chk("loss_cnt_rst", 32'(loss_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
